// File: rtl/ex_stage_mc_if.sv
// Handshake and result bus between the decode stage and the multi-cycle
// execute stage. The master side drives the instruction, the slave
// side (the execute stage) drives stall and the registered results.
interface ex_stage_mc_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              flush_i;
  logic              valid_i;
  logic [7:0]        aluop_i;
  logic [2:0]        alusel_i;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  logic [ADDR_W-1:0] wd_i;
  logic              wreg_i;
  logic              stall_o;
  logic              valid_o;
  logic [ADDR_W-1:0] wd_o;
  logic              wreg_o;
  logic [DATA_W-1:0] wdata_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output flush_i, valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  stall_o, valid_o, wd_o, wreg_o, wdata_o, hi_o, lo_o
  );

  modport slave (
    input  flush_i, valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output stall_o, valid_o, wd_o, wreg_o, wdata_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_stage_mc.sv
// Execute stage with single-cycle ALU, one-cycle multiplier and a
// bit-serial restoring divider that stalls upstream while it runs.
// Multiply/divide results land only in the HI/LO registers.
module ex_stage_mc #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  ex_stage_mc_if.slave bus
);
  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int CNT_W   = SHAMT_W;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_ARITH = 3'd3;
  localparam logic [2:0] SEL_MOVE  = 3'd4;
  localparam logic [2:0] SEL_MDU   = 3'd5;

  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_ADDU  = 8'h21;
  localparam logic [7:0] OP_SUBU  = 8'h23;
  localparam logic [7:0] OP_SLT   = 8'h2A;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h12;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   wd_q, wd_d;
  logic                wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W-1:0]   alu_res;
  logic                is_mdu, is_div, is_mul, div_signed, mul_signed, divisor_zero;
  logic [DATA_W-1:0]   dvd_mag, dvs_mag;
  logic [2*DATA_W-1:0] mul_a, mul_b, product;
  logic [DATA_W:0]     div_shift, div_trial;
  logic                div_fits, stall;

  assign shamt        = bus.reg1_i[SHAMT_W-1:0];
  assign is_mdu       = bus.valid_i && (bus.alusel_i == SEL_MDU);
  assign is_div       = is_mdu && (bus.aluop_i == OP_DIV || bus.aluop_i == OP_DIVU);
  assign is_mul       = is_mdu && (bus.aluop_i == OP_MULT || bus.aluop_i == OP_MULTU);
  assign div_signed   = (bus.aluop_i == OP_DIV);
  assign mul_signed   = (bus.aluop_i == OP_MULT);
  assign divisor_zero = (bus.reg2_i == '0);

  // Signed divide works on magnitudes; signs are reapplied when done.
  assign dvd_mag = (div_signed && bus.reg1_i[DATA_W-1]) ? -bus.reg1_i : bus.reg1_i;
  assign dvs_mag = (div_signed && bus.reg2_i[DATA_W-1]) ? -bus.reg2_i : bus.reg2_i;

  // Low 2W bits of the product of extended operands give both signed and unsigned results.
  assign mul_a   = mul_signed ? {{DATA_W{bus.reg1_i[DATA_W-1]}}, bus.reg1_i}
                              : {{DATA_W{1'b0}}, bus.reg1_i};
  assign mul_b   = mul_signed ? {{DATA_W{bus.reg2_i[DATA_W-1]}}, bus.reg2_i}
                              : {{DATA_W{1'b0}}, bus.reg2_i};
  assign product = mul_a * mul_b;

  // One restoring step: shift the next dividend bit into the remainder and try to subtract.
  assign div_shift = {rem_q, quo_q[DATA_W-1]};
  assign div_trial = div_shift - {1'b0, dvs_q};
  assign div_fits  = ~div_trial[DATA_W];

  // Stall while the divider is launching or iterating; a flush in the launch cycle cancels it.
  assign stall = (state_q == S_RUN) ||
                 ((state_q == S_IDLE) && !bus.flush_i && is_div && !divisor_zero);

  // Single-cycle result selected by class, then by operation code.
  always_comb begin
    alu_res = '0;
    case (bus.alusel_i)
      SEL_LOGIC: case (bus.aluop_i)
        OP_OR:   alu_res = bus.reg1_i | bus.reg2_i;
        OP_AND:  alu_res = bus.reg1_i & bus.reg2_i;
        OP_XOR:  alu_res = bus.reg1_i ^ bus.reg2_i;
        OP_NOR:  alu_res = ~(bus.reg1_i | bus.reg2_i);
        default: alu_res = '0;
      endcase
      SEL_SHIFT: case (bus.aluop_i)
        OP_SLL:  alu_res = bus.reg2_i << shamt;
        OP_SRL:  alu_res = bus.reg2_i >> shamt;
        OP_SRA:  alu_res = $unsigned($signed(bus.reg2_i) >>> shamt);
        default: alu_res = '0;
      endcase
      SEL_ARITH: case (bus.aluop_i)
        OP_ADDU: alu_res = bus.reg1_i + bus.reg2_i;
        OP_SUBU: alu_res = bus.reg1_i - bus.reg2_i;
        OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(bus.reg1_i) < $signed(bus.reg2_i))};
        default: alu_res = '0;
      endcase
      SEL_MOVE: case (bus.aluop_i)
        OP_MFHI: alu_res = hi_q;
        OP_MFLO: alu_res = lo_q;
        default: alu_res = '0;
      endcase
      default: alu_res = '0;
    endcase
  end

  // Divider FSM, HI/LO updates and output slot; every path not issuing a result loads a bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    valid_d = 1'b0;
    wd_d    = '0;
    wreg_d  = 1'b0;
    wdata_d = '0;
    if (bus.flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.valid_i) begin
            if (is_div && !divisor_zero) begin
              state_d = S_RUN;
              cnt_d   = '0;
              rem_d   = '0;
              quo_d   = dvd_mag;
              dvs_d   = dvs_mag;
              q_neg_d = div_signed && (bus.reg1_i[DATA_W-1] ^ bus.reg2_i[DATA_W-1]);
              r_neg_d = div_signed && bus.reg1_i[DATA_W-1];
            end else begin
              valid_d = 1'b1;
              wd_d    = bus.wd_i;
              if (is_mdu) begin
                if (is_div) begin
                  hi_d = bus.reg1_i;
                  lo_d = '1;
                end else if (is_mul) begin
                  {hi_d, lo_d} = product;
                end
              end else begin
                wreg_d  = bus.wreg_i;
                wdata_d = alu_res;
              end
            end
          end
        end
        S_RUN: begin
          cnt_d = cnt_q + CNT_W'(1);
          rem_d = div_fits ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], div_fits};
          if (cnt_q == LAST_ITER) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          hi_d    = r_neg_q ? -rem_q : rem_q;
          lo_d    = q_neg_q ? -quo_q : quo_q;
          valid_d = 1'b1;
          wd_d    = bus.wd_i;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.stall_o = stall;
  assign bus.valid_o = valid_q;
  assign bus.wd_o    = wd_q;
  assign bus.wreg_o  = wreg_q;
  assign bus.wdata_o = wdata_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
endmodule

// File: tb/tb_ex_stage_mc.sv
// Bench for the multi-cycle execute stage: directed vectors followed by
// random operations checked against an arithmetic reference model.
module tb_ex_stage_mc;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int DIV_STALL = DATA_W + 1;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [7:0]  op_table [16];

  ex_stage_mc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ex_stage_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic flush, input logic valid, input logic [7:0] op,
                               input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] wd, input logic wr);
    bus.flush_i  = flush;
    bus.valid_i  = valid;
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = a;
    bus.reg2_i   = b;
    bus.wd_i     = wd;
    bus.wreg_i   = wr;
  endtask

  // Reference result of a non-MDU instruction, from the instruction set rules.
  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
    int     sh;
    longint sb;
    sh = int'(a[4:0]);
    sb = longint'($signed(b));
    ref_alu = '0;
    case (sel)
      3'd1: case (op)
        8'h25: ref_alu = a | b;
        8'h24: ref_alu = a & b;
        8'h26: ref_alu = a ^ b;
        8'h27: ref_alu = ~(a | b);
        default: ref_alu = '0;
      endcase
      3'd2: case (op)
        8'h7C: ref_alu = b << sh;
        8'h02: ref_alu = b >> sh;
        8'h03: ref_alu = 32'(sb >>> sh);
        default: ref_alu = '0;
      endcase
      3'd3: case (op)
        8'h21: ref_alu = a + b;
        8'h23: ref_alu = a - b;
        8'h2A: ref_alu = (longint'($signed(a)) < sb) ? 32'd1 : 32'd0;
        default: ref_alu = '0;
      endcase
      3'd4: case (op)
        8'h10: ref_alu = exp_hi;
        8'h12: ref_alu = exp_lo;
        default: ref_alu = '0;
      endcase
      default: ref_alu = '0;
    endcase
  endfunction

  // Issue one instruction, wait out any divide stall, then check the output slot and HI/LO.
  task automatic runOp(input string tag, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd, input logic wr);
    logic [31:0] exp_data, nh, nl;
    logic        exp_wreg, long_div;
    logic [63:0] p;
    longint      sa, sb;
    int          n;
    nh = exp_hi;
    nl = exp_lo;
    exp_data = '0;
    exp_wreg = 1'b0;
    long_div = 1'b0;
    if (sel == 3'd5) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
        8'h18: begin p = 64'(sa * sb); {nh, nl} = p; end
        8'h19: begin p = {32'b0, a} * {32'b0, b}; {nh, nl} = p; end
        8'h1A, 8'h1B: begin
          if (b == '0) begin
            nh = a;
            nl = '1;
          end else begin
            long_div = 1'b1;
            if (op == 8'h1B) begin
              sa = longint'({32'b0, a});
              sb = longint'({32'b0, b});
            end
            nl = 32'(sa / sb);
            nh = 32'(sa % sb);
          end
        end
        default: ;
      endcase
    end else begin
      exp_data = ref_alu(op, sel, a, b);
      exp_wreg = wr;
    end
    applyStimulus(1'b0, 1'b1, op, sel, a, b, wd, wr);
    #1;
    if (long_div) begin
      n = 0;
      while (bus.stall_o === 1'b1 && n < 200) begin
        if (n == 2) begin
          checkOutput({tag, "_stall_valid"}, bus.valid_o, 1'b0);
          checkOutput({tag, "_stall_wdata"}, bus.wdata_o, 32'h0);
        end
        n++;
        @(negedge clk);
        #1;
      end
      checkOutput({tag, "_stall_cycles"}, n, DIV_STALL);
    end else begin
      checkOutput({tag, "_nostall"}, bus.stall_o, 1'b0);
    end
    @(negedge clk);
    checkOutput({tag, "_valid"}, bus.valid_o, 1'b1);
    checkOutput({tag, "_wd"},    bus.wd_o, wd);
    checkOutput({tag, "_wreg"},  bus.wreg_o, exp_wreg);
    checkOutput({tag, "_wdata"}, bus.wdata_o, exp_data);
    checkOutput({tag, "_hi"},    bus.hi_o, nh);
    checkOutput({tag, "_lo"},    bus.lo_o, nl);
    exp_hi = nh;
    exp_lo = nl;
  endtask

  initial begin
    logic [7:0]  r_op;
    logic [2:0]  r_sel;
    logic [31:0] r_a, r_b;
    op_table = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'h21,
                 8'h23, 8'h2A, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h10, 8'h12};

    // Reset
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h0, 3'd0, '0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_valid", bus.valid_o, 1'b0);
    checkOutput("rst_wd",    bus.wd_o, 5'd0);
    checkOutput("rst_wreg",  bus.wreg_o, 1'b0);
    checkOutput("rst_wdata", bus.wdata_o, 32'h0);
    checkOutput("rst_hi",    bus.hi_o, 32'h0);
    checkOutput("rst_lo",    bus.lo_o, 32'h0);
    checkOutput("rst_stall", bus.stall_o, 1'b0);

    // Shifts, including arithmetic fill and zero shift amount
    runOp("sra", 8'h03, 3'd2, 32'd4, 32'h8000_0000, 5'd3, 1'b1);
    checkOutput("sra_const", bus.wdata_o, 32'hF800_0000);
    runOp("sll0", 8'h7C, 3'd2, 32'd0, 32'h0000_1234, 5'd4, 1'b1);
    checkOutput("sll0_const", bus.wdata_o, 32'h0000_1234);

    // Multiply then read LO back
    runOp("mult", 8'h18, 3'd5, 32'hFFFF_FFFE, 32'd3, 5'd7, 1'b1);
    checkOutput("mult_hi_const", bus.hi_o, 32'hFFFF_FFFF);
    checkOutput("mult_lo_const", bus.lo_o, 32'hFFFF_FFFA);
    runOp("mflo", 8'h12, 3'd4, 32'd0, 32'd0, 5'd8, 1'b1);
    checkOutput("mflo_const", bus.wdata_o, 32'hFFFF_FFFA);

    // Bubble when idle
    applyStimulus(1'b0, 1'b0, 8'h21, 3'd3, 32'd5, 32'd6, 5'd9, 1'b1);
    @(negedge clk);
    checkOutput("idle_valid", bus.valid_o, 1'b0);
    checkOutput("idle_wd",    bus.wd_o, 5'd0);
    checkOutput("idle_wreg",  bus.wreg_o, 1'b0);

    // Divides: signed, divide by zero, overflow corner, mixed signs
    runOp("div_m7_2", 8'h1A, 3'd5, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1);
    checkOutput("div_lo_const", bus.lo_o, 32'hFFFF_FFFD);
    checkOutput("div_hi_const", bus.hi_o, 32'hFFFF_FFFF);
    runOp("divu_by0", 8'h1B, 3'd5, 32'd7, 32'd0, 5'd11, 1'b1);
    checkOutput("divu0_hi_const", bus.hi_o, 32'h7);
    checkOutput("divu0_lo_const", bus.lo_o, 32'hFFFF_FFFF);

    // Flush during divider iteration 5
    applyStimulus(1'b0, 1'b1, 8'h1B, 3'd5, 32'd100, 32'd7, 5'd12, 1'b1);
    @(negedge clk);
    repeat (5) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 8'h0, 3'd0, '0, '0, '0, 1'b0);
    #1;
    checkOutput("flush_stall", bus.stall_o, 1'b0);
    checkOutput("flush_valid", bus.valid_o, 1'b0);
    checkOutput("flush_hi",    bus.hi_o, exp_hi);
    checkOutput("flush_lo",    bus.lo_o, exp_lo);
    @(negedge clk);
    runOp("addu_after_flush", 8'h21, 3'd3, 32'd1, 32'd1, 5'd13, 1'b1);
    checkOutput("addu_const", bus.wdata_o, 32'd2);

    runOp("div_minneg", 8'h1A, 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);
    checkOutput("minneg_lo_const", bus.lo_o, 32'h8000_0000);
    checkOutput("minneg_hi_const", bus.hi_o, 32'h0);
    runOp("div_7_m2", 8'h1A, 3'd5, 32'd7, 32'hFFFF_FFFE, 5'd15, 1'b1);
    runOp("bad_op", 8'hFF, 3'd1, 32'h1234, 32'h5678, 5'd16, 1'b1);
    checkOutput("bad_op_wreg", bus.wreg_o, 1'b1);
    runOp("slt_neg", 8'h2A, 3'd3, 32'hFFFF_FFFF, 32'd1, 5'd17, 1'b1);
    runOp("subu_wrap", 8'h23, 3'd3, 32'd0, 32'd1, 5'd18, 1'b1);

    // Random operations
    for (int i = 0; i < 80; i++) begin
      r_sel = 3'($urandom_range(0, 7));
      if (r_sel == 3'd5) r_op = op_table[$urandom_range(10, 13)];
      else if ($urandom_range(0, 7) == 0) r_op = 8'($urandom);
      else r_op = op_table[$urandom_range(0, 15)];
      r_a = $urandom;
      r_b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 20));
      runOp("rand", r_op, r_sel, r_a, r_b, 5'($urandom), 1'($urandom));
    end

    // Reset during divider iteration 10
    applyStimulus(1'b0, 1'b1, 8'h1A, 3'd5, 32'd1000, 32'd3, 5'd19, 1'b1);
    @(negedge clk);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h0, 3'd0, '0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstrun_stall", bus.stall_o, 1'b0);
    checkOutput("rstrun_valid", bus.valid_o, 1'b0);
    checkOutput("rstrun_wd",    bus.wd_o, 5'd0);
    checkOutput("rstrun_wreg",  bus.wreg_o, 1'b0);
    checkOutput("rstrun_wdata", bus.wdata_o, 32'h0);
    checkOutput("rstrun_hi",    bus.hi_o, 32'h0);
    checkOutput("rstrun_lo",    bus.lo_o, 32'h0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    runOp("after_rst_or", 8'h25, 3'd1, 32'hF0F0_0000, 32'h0000_0F0F, 5'd20, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
